// File: rtl/softmax_frame_sequencer_if.sv
// Stream, pipeline and result signals of softmax_frame_sequencer grouped into one bundle.
// The sequencer connects through the slave modport; its environment uses master.
interface softmax_frame_sequencer_if #(
    parameter int data_size      = 32,
    parameter int number_of_data = 10
);
    localparam int IW = $clog2(number_of_data);

    logic                 in_valid_i;
    logic [data_size-1:0] in_data_i;
    logic                 in_last_i;
    logic                 in_ready_o;

    logic                 pipe_start_o;
    logic [data_size-1:0] pipe_data_o;
    logic [data_size-1:0] pipe_result_i;
    logic                 pipe_result_valid_i;

    logic [data_size-1:0] out_data_o;
    logic                 out_valid_o;
    logic [IW-1:0]        out_index_o;
    logic                 out_last_o;
    logic                 frame_done_o;
    logic                 busy_o;
    logic                 len_err_o;

    modport slave (
        input  in_valid_i, in_data_i, in_last_i, pipe_result_i, pipe_result_valid_i,
        output in_ready_o, pipe_start_o, pipe_data_o, out_data_o, out_valid_o,
               out_index_o, out_last_o, frame_done_o, busy_o, len_err_o
    );

    modport master (
        output in_valid_i, in_data_i, in_last_i, pipe_result_i, pipe_result_valid_i,
        input  in_ready_o, pipe_start_o, pipe_data_o, out_data_o, out_valid_o,
               out_index_o, out_last_o, frame_done_o, busy_o, len_err_o
    );
endinterface

// File: rtl/softmax_frame_sequencer.sv
// Frame controller for the softmax pipeline: buffers one frame, replays it, collects and tags results.
// Optional result-wait watchdog enabled by defining SOFTMAX_SEQ_TIMEOUT_EN.
module softmax_frame_sequencer #(
    parameter int data_size      = 32,
    parameter int number_of_data = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    softmax_frame_sequencer_if.slave sif
);
    localparam int IW = $clog2(number_of_data);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(number_of_data - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(number_of_data);

    if (number_of_data < 2) begin : g_bad_frame_len
        $error("number_of_data must be at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_WAIT,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [data_size-1:0] r_buf [number_of_data];
    logic [CW-1:0]        r_wr_cnt;
    logic [CW-1:0]        r_st_cnt;
    logic [CW-1:0]        r_rd_cnt;

    logic [data_size-1:0] r_out_data;
    logic                 r_out_valid;
    logic [IW-1:0]        r_out_index;
    logic                 r_out_last;
    logic                 r_len_err;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_last_word;
    logic                 w_early_last;
    logic                 w_no_last;
    logic                 w_result;
    logic                 w_timeout;
    logic                 w_pipe_start;
    logic [data_size-1:0] w_pipe_data;
    logic                 w_frame_done;

    assign w_ready      = ((r_state == S_IDLE) || (r_state == S_LOAD)) && !reset_i;
    assign w_accept     = sif.in_valid_i && w_ready;
    // r_wr_cnt is 0 in IDLE, so these decodes hold for the first word as well.
    assign w_last_word  = (r_wr_cnt == LAST_IDX);
    assign w_early_last = w_accept && sif.in_last_i && !w_last_word;
    assign w_no_last    = w_accept && !sif.in_last_i && w_last_word;
    assign w_result     = (r_state == S_WAIT) && sif.pipe_result_valid_i && (r_rd_cnt != FULL_CNT);

`ifdef SOFTMAX_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] r_wdog;

    assign w_timeout = (r_state == S_WAIT) && !sif.pipe_result_valid_i &&
                       (r_rd_cnt != FULL_CNT) && (r_wdog == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock_i) begin
        if (reset_i || (r_state != S_WAIT) || sif.pipe_result_valid_i || w_timeout) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next       = r_state;
        w_pipe_start = 1'b0;
        w_pipe_data  = '0;
        w_frame_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_early_last ? S_IDLE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_early_last) begin
                    w_next = S_IDLE;
                end else if (w_accept && w_last_word) begin
                    w_next = S_STREAM;
                end
            end
            S_STREAM: begin
                w_pipe_start = (r_st_cnt == '0);
                w_pipe_data  = r_buf[r_st_cnt[IW-1:0]];
                if (r_st_cnt == LAST_IDX) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // Leave one cycle after the final result so frame_done trails the last out_valid.
                if (r_rd_cnt == FULL_CNT) begin
                    w_next = S_DONE;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_DONE: begin
                w_frame_done = 1'b1;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: the frame buffer is deliberately not reset; it is always written before it is read.
    always_ff @(posedge clock_i) begin
        if (w_accept) begin
            r_buf[r_wr_cnt[IW-1:0]] <= sif.in_data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_wr_cnt    <= '0;
            r_st_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            r_out_valid <= w_result;
            r_len_err   <= w_early_last || w_no_last || w_timeout;

            if (w_accept) begin
                r_wr_cnt <= (w_early_last || w_last_word) ? '0 : r_wr_cnt + 1'b1;
            end

            if (r_state == S_STREAM) begin
                r_st_cnt <= (r_st_cnt == LAST_IDX) ? '0 : r_st_cnt + 1'b1;
            end

            if (w_result) begin
                r_out_data  <= sif.pipe_result_i;
                r_out_index <= r_rd_cnt[IW-1:0];
                r_out_last  <= (r_rd_cnt == LAST_IDX);
                r_rd_cnt    <= r_rd_cnt + 1'b1;
            end else if ((r_state == S_DONE) || w_timeout) begin
                r_rd_cnt <= '0;
            end
        end
    end

    assign sif.in_ready_o   = w_ready;
    assign sif.pipe_start_o = w_pipe_start;
    assign sif.pipe_data_o  = w_pipe_data;
    assign sif.out_data_o   = r_out_data;
    assign sif.out_valid_o  = r_out_valid;
    assign sif.out_index_o  = r_out_index;
    assign sif.out_last_o   = r_out_last;
    assign sif.frame_done_o = w_frame_done;
    assign sif.busy_o       = (r_state != S_IDLE);
    assign sif.len_err_o    = r_len_err;

endmodule

// File: tb/tb_softmax_frame_sequencer.sv
// Self-checking bench for softmax_frame_sequencer: random frames and result streams
// compared against a frame-level model of replay order, tagging and timing.
module tb_softmax_frame_sequencer;
    localparam int DW = 32;
    localparam int N  = 10;
`ifdef SOFTMAX_SEQ_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    typedef logic [DW-1:0] word_t;
    typedef word_t frame_t [N];
    typedef struct { word_t d; logic s; int c; } pipe_ev_t;
    typedef struct { word_t d; int idx; logic l; int c; } out_ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    pipe_ev_t pipe_q[$];
    out_ev_t  out_q[$];
    int       done_q[$];
    int       err_q[$];
    bit       ready_h [8192];
    bit       busy_h  [8192];

    always #5 clk = ~clk;

    softmax_frame_sequencer_if #(.data_size(DW), .number_of_data(N)) u_if ();

    softmax_frame_sequencer #(
        .data_size(DW),
        .number_of_data(N),
        .TIMEOUT_CYCLES(TMO)
    ) u_dut (
        .clock_i(clk),
        .reset_i(rst),
        .sif    (u_if)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u_if.pipe_start_o || (u_if.pipe_data_o != '0))
            pipe_q.push_back('{u_if.pipe_data_o, u_if.pipe_start_o, cyc});
        if (u_if.out_valid_o === 1'b1)
            out_q.push_back('{u_if.out_data_o, int'(u_if.out_index_o), u_if.out_last_o, cyc});
        if (u_if.frame_done_o === 1'b1) done_q.push_back(cyc);
        if (u_if.len_err_o === 1'b1) err_q.push_back(cyc);
        if (cyc < 8192) begin
            ready_h[cyc] <= u_if.in_ready_o;
            busy_h[cyc]  <= u_if.busy_o;
        end
    end

    function automatic frame_t rand_frame();
        frame_t f;
        for (int i = 0; i < N; i++) f[i] = $urandom | 32'h1;
        return f;
    endfunction

    task automatic clear_mon();
        pipe_q.delete();
        out_q.delete();
        done_q.delete();
        err_q.delete();
    endtask

    task automatic push_word(input word_t d, input logic last, input int mingap, input int maxgap,
                             output int acc);
        bit ok = 1'b0;
        repeat ($urandom_range(maxgap, mingap)) begin
            u_if.in_valid_i = 1'b0;
            @(posedge clk); #1;
        end
        u_if.in_valid_i = 1'b1;
        u_if.in_data_i  = d;
        u_if.in_last_i  = last;
        for (int t = 0; t < 64 && !ok; t++) begin
            ok = u_if.in_ready_o;
            @(posedge clk); #1;
        end
        acc = cyc;
        u_if.in_valid_i = 1'b0;
        u_if.in_last_i  = 1'b0;
        u_if.in_data_i  = '0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL accept_wait: in_ready_o never high for word %0h within 64 cycles", d);
        end
    endtask

    task automatic send_frame(input frame_t w, input int nwords, input int last_at,
                              input int mingap, input int maxgap, output int acc);
        for (int i = 0; i < nwords; i++) push_word(w[i], (i == last_at), mingap, maxgap, acc);
    endtask

    task automatic feed_results(input frame_t r, input int cnt, input int maxgap, output int ec [N]);
        for (int k = 0; k < N; k++) ec[k] = 0;
        for (int k = 0; k < cnt; k++) begin
            repeat ($urandom_range(maxgap, 0)) begin
                u_if.pipe_result_valid_i = 1'b0;
                u_if.pipe_result_i       = $urandom;
                @(posedge clk); #1;
            end
            u_if.pipe_result_valid_i = 1'b1;
            u_if.pipe_result_i       = r[k];
            @(posedge clk); #1;
            ec[k] = cyc;
        end
        u_if.pipe_result_valid_i = 1'b0;
        u_if.pipe_result_i       = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (u_if.in_ready_o !== 1'b1) begin
            bad++; $display("FAIL reset_ready: got %b want 1", u_if.in_ready_o);
        end
        total++;
        if (u_if.busy_o !== 1'b0) begin
            bad++; $display("FAIL reset_busy: got %b want 0", u_if.busy_o);
        end
        total++;
        if ({u_if.pipe_start_o, u_if.pipe_data_o} !== '0) begin
            bad++; $display("FAIL reset_pipe: got start=%b data=%0h want 0", u_if.pipe_start_o, u_if.pipe_data_o);
        end
        total++;
        if ({u_if.out_valid_o, u_if.out_data_o, u_if.out_index_o, u_if.out_last_o} !== '0) begin
            bad++; $display("FAIL reset_out: got v=%b d=%0h i=%0d l=%b want 0", u_if.out_valid_o,
                            u_if.out_data_o, u_if.out_index_o, u_if.out_last_o);
        end
        total++;
        if ({u_if.frame_done_o, u_if.len_err_o} !== 2'b00) begin
            bad++; $display("FAIL reset_flags: got done=%b err=%b want 0", u_if.frame_done_o, u_if.len_err_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stream_and_results();
        frame_t w, r;
        int acc, hi;
        int ec [N];
        for (int i = 0; i < N; i++) begin
            w[i] = word_t'(i + 1);
            r[i] = word_t'(32'hA0 + i);
        end
        clear_mon();
        send_frame(w, N, N - 1, 0, 0, acc);
        repeat (N) @(posedge clk); #1;
        feed_results(r, N, 3, ec);
        repeat (3) @(posedge clk); #1;
        total++;
        if (pipe_q.size() != N) begin
            bad++; $display("FAIL basic_stream_len: got %0d want %0d", pipe_q.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                total++;
                if (pipe_q[i].d !== w[i] || pipe_q[i].s !== (i == 0) || pipe_q[i].c != acc + i) begin
                    bad++; $display("FAIL basic_stream[%0d]: got d=%0h s=%b c=%0d want d=%0h s=%b c=%0d",
                                    i, pipe_q[i].d, pipe_q[i].s, pipe_q[i].c, w[i], (i == 0), acc + i);
                end
            end
        end
        hi = 0;
        for (int c = acc; c <= ec[N-1] + 1; c++) hi += ready_h[c];
        total++;
        if (hi != 0) begin
            bad++; $display("FAIL basic_ready_low: got %0d ready cycles want 0", hi);
        end
        total++;
        if (out_q.size() != N) begin
            bad++; $display("FAIL basic_out_len: got %0d want %0d", out_q.size(), N);
        end else begin
            for (int k = 0; k < N; k++) begin
                total++;
                if (out_q[k].d !== r[k] || out_q[k].idx != k || out_q[k].l !== (k == N - 1) ||
                    out_q[k].c != ec[k]) begin
                    bad++; $display("FAIL basic_out[%0d]: got d=%0h i=%0d l=%b c=%0d want d=%0h i=%0d l=%b c=%0d",
                                    k, out_q[k].d, out_q[k].idx, out_q[k].l, out_q[k].c, r[k], k, (k == N - 1), ec[k]);
                end
            end
        end
        total++;
        if (done_q.size() != 1 || done_q[0] != ec[N-1] + 1) begin
            bad++; $display("FAIL basic_frame_done: got %0d pulses first at %0d want 1 at %0d",
                            done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, ec[N-1] + 1);
        end
        total++;
        if (busy_h[ec[N-1] + 1] !== 1'b1 || busy_h[ec[N-1] + 2] !== 1'b0 || ready_h[ec[N-1] + 2] !== 1'b1) begin
            bad++; $display("FAIL basic_busy_fall: got busy=%b,%b ready=%b want 1,0 ready 1",
                            busy_h[ec[N-1] + 1], busy_h[ec[N-1] + 2], ready_h[ec[N-1] + 2]);
        end
        total++;
        if (err_q.size() != 0) begin
            bad++; $display("FAIL basic_no_err: got %0d len_err pulses want 0", err_q.size());
        end
    endtask

    task automatic test_stall();
        frame_t w, r;
        int acc;
        int ec [N];
        w = rand_frame();
        r = rand_frame();
        clear_mon();
        send_frame(w, N, N - 1, 1, 1, acc);
        repeat (N) @(posedge clk); #1;
        feed_results(r, N, 4, ec);
        repeat (3) @(posedge clk); #1;
        total++;
        if (pipe_q.size() != N) begin
            bad++; $display("FAIL stall_stream_len: got %0d want %0d", pipe_q.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                total++;
                if (pipe_q[i].d !== w[i] || pipe_q[i].s !== (i == 0) || pipe_q[i].c != acc + i) begin
                    bad++; $display("FAIL stall_stream[%0d]: got d=%0h s=%b c=%0d want d=%0h s=%b c=%0d",
                                    i, pipe_q[i].d, pipe_q[i].s, pipe_q[i].c, w[i], (i == 0), acc + i);
                end
            end
        end
        total++;
        if (err_q.size() != 0) begin
            bad++; $display("FAIL stall_no_err: got %0d len_err pulses want 0", err_q.size());
        end
        total++;
        if (out_q.size() != N || done_q.size() != 1) begin
            bad++; $display("FAIL stall_drain: got %0d results %0d done want %0d and 1", out_q.size(), done_q.size(), N);
        end else begin
            for (int k = 0; k < N; k++) begin
                total++;
                if (out_q[k].d !== r[k] || out_q[k].idx != k) begin
                    bad++; $display("FAIL stall_out[%0d]: got d=%0h i=%0d want d=%0h i=%0d",
                                    k, out_q[k].d, out_q[k].idx, r[k], k);
                end
            end
        end
    endtask

    task automatic test_early_last();
        frame_t w, w2, r;
        int acc, acc2;
        int ec [N];
        w  = rand_frame();
        w2 = rand_frame();
        r  = rand_frame();
        clear_mon();
        send_frame(w, 4, 3, 0, 2, acc);
        repeat (3) @(posedge clk); #1;
        total++;
        if (err_q.size() != 1 || err_q[0] != acc) begin
            bad++; $display("FAIL early_len_err: got %0d pulses first at %0d want 1 at %0d",
                            err_q.size(), (err_q.size() > 0) ? err_q[0] : -1, acc);
        end
        total++;
        if (pipe_q.size() != 0) begin
            bad++; $display("FAIL early_no_stream: got %0d pipe cycles want 0", pipe_q.size());
        end
        total++;
        if (u_if.busy_o !== 1'b0 || u_if.in_ready_o !== 1'b1) begin
            bad++; $display("FAIL early_idle: got busy=%b ready=%b want 0 1", u_if.busy_o, u_if.in_ready_o);
        end
        send_frame(w2, N, N - 1, 0, 2, acc2);
        repeat (N) @(posedge clk); #1;
        feed_results(r, N, 2, ec);
        repeat (3) @(posedge clk); #1;
        total++;
        if (pipe_q.size() != N) begin
            bad++; $display("FAIL early_next_len: got %0d want %0d", pipe_q.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                total++;
                if (pipe_q[i].d !== w2[i] || pipe_q[i].c != acc2 + i) begin
                    bad++; $display("FAIL early_next[%0d]: got d=%0h c=%0d want d=%0h c=%0d",
                                    i, pipe_q[i].d, pipe_q[i].c, w2[i], acc2 + i);
                end
            end
        end
        total++;
        if (done_q.size() != 1 || out_q.size() != N || err_q.size() != 1) begin
            bad++; $display("FAIL early_next_drain: got done=%0d out=%0d err=%0d want 1 %0d 1",
                            done_q.size(), out_q.size(), err_q.size(), N);
        end
    endtask

    task automatic test_missing_last();
        frame_t w, w2, r, r2;
        int acc, acc2;
        int ec [N];
        w  = rand_frame();
        w2 = rand_frame();
        r  = rand_frame();
        r2 = rand_frame();
        clear_mon();
        send_frame(w, N, -1, 0, 1, acc);
        repeat (N) @(posedge clk); #1;
        feed_results(r, N, 1, ec);
        send_frame(w2, N, N - 1, 0, 0, acc2);
        repeat (N) @(posedge clk); #1;
        feed_results(r2, N, 1, ec);
        repeat (3) @(posedge clk); #1;
        total++;
        if (err_q.size() != 1 || err_q[0] != acc) begin
            bad++; $display("FAIL nolast_len_err: got %0d pulses first at %0d want 1 at %0d",
                            err_q.size(), (err_q.size() > 0) ? err_q[0] : -1, acc);
        end
        total++;
        if (pipe_q.size() != 2 * N || out_q.size() != 2 * N || done_q.size() != 2) begin
            bad++; $display("FAIL nolast_counts: got pipe=%0d out=%0d done=%0d want %0d %0d 2",
                            pipe_q.size(), out_q.size(), done_q.size(), 2 * N, 2 * N);
        end else begin
            for (int i = 0; i < 2 * N; i++) begin
                total++;
                if (pipe_q[i].d !== ((i < N) ? w[i] : w2[i-N]) || out_q[i].d !== ((i < N) ? r[i] : r2[i-N])) begin
                    bad++; $display("FAIL nolast_data[%0d]: got pipe=%0h out=%0h want %0h %0h", i,
                                    pipe_q[i].d, out_q[i].d, (i < N) ? w[i] : w2[i-N], (i < N) ? r[i] : r2[i-N]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        frame_t w, r;
        int acc;
        int ec [N];
        w = rand_frame();
        r = rand_frame();
        clear_mon();
        send_frame(w, N, N - 1, 0, 1, acc);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({u_if.pipe_start_o, u_if.pipe_data_o, u_if.busy_o, u_if.out_valid_o,
             u_if.frame_done_o, u_if.len_err_o} !== '0) begin
            bad++; $display("FAIL midreset_outputs: got start=%b data=%0h busy=%b valid=%b done=%b err=%b want all 0",
                            u_if.pipe_start_o, u_if.pipe_data_o, u_if.busy_o, u_if.out_valid_o,
                            u_if.frame_done_o, u_if.len_err_o);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        feed_results(r, 5, 2, ec);
        repeat (3) @(posedge clk); #1;
        total++;
        if (out_q.size() != 0) begin
            bad++; $display("FAIL midreset_stray_results: got %0d out_valid want 0", out_q.size());
        end
        total++;
        if (pipe_q.size() != 5) begin
            bad++; $display("FAIL midreset_stream_cut: got %0d pipe cycles want 5", pipe_q.size());
        end
        total++;
        if (u_if.busy_o !== 1'b0 || u_if.in_ready_o !== 1'b1 || done_q.size() != 0) begin
            bad++; $display("FAIL midreset_idle: got busy=%b ready=%b done=%0d want 0 1 0",
                            u_if.busy_o, u_if.in_ready_o, done_q.size());
        end
    endtask

    task automatic test_back_to_back();
        localparam int FRAMES = 6;
        frame_t w, r;
        int acc;
        int ec [N];
        word_t exp_pipe[$];
        word_t exp_out[$];
        clear_mon();
        for (int f = 0; f < FRAMES; f++) begin
            w = rand_frame();
            r = rand_frame();
            for (int i = 0; i < N; i++) begin
                exp_pipe.push_back(w[i]);
                exp_out.push_back(r[i]);
            end
            send_frame(w, N, N - 1, 0, $urandom_range(3, 0), acc);
            repeat (N) @(posedge clk); #1;
            feed_results(r, N, $urandom_range(2, 0), ec);
        end
        repeat (3) @(posedge clk); #1;
        total++;
        if (pipe_q.size() != FRAMES * N || out_q.size() != FRAMES * N) begin
            bad++; $display("FAIL b2b_counts: got pipe=%0d out=%0d want %0d", pipe_q.size(), out_q.size(), FRAMES * N);
        end else begin
            for (int i = 0; i < FRAMES * N; i++) begin
                total++;
                if (pipe_q[i].d !== exp_pipe[i] || pipe_q[i].s !== (i % N == 0) ||
                    pipe_q[i].c != pipe_q[i - i % N].c + i % N) begin
                    bad++; $display("FAIL b2b_pipe[%0d]: got d=%0h s=%b c=%0d want d=%0h s=%b c=%0d", i,
                                    pipe_q[i].d, pipe_q[i].s, pipe_q[i].c, exp_pipe[i], (i % N == 0),
                                    pipe_q[i - i % N].c + i % N);
                end
                total++;
                if (out_q[i].d !== exp_out[i] || out_q[i].idx != i % N || out_q[i].l !== (i % N == N - 1)) begin
                    bad++; $display("FAIL b2b_out[%0d]: got d=%0h i=%0d l=%b want d=%0h i=%0d l=%b", i,
                                    out_q[i].d, out_q[i].idx, out_q[i].l, exp_out[i], i % N, (i % N == N - 1));
                end
            end
        end
        total++;
        if (done_q.size() != FRAMES || err_q.size() != 0) begin
            bad++; $display("FAIL b2b_flags: got done=%0d err=%0d want %0d 0", done_q.size(), err_q.size(), FRAMES);
        end
    endtask

`ifdef SOFTMAX_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        frame_t w, r;
        int acc;
        int ec [N];
        w = rand_frame();
        r = rand_frame();
        clear_mon();
        send_frame(w, N, N - 1, 0, 1, acc);
        repeat (N) @(posedge clk); #1;
        feed_results(r, 3, 2, ec);
        repeat (TMO + 4) @(posedge clk); #1;
        total++;
        if (err_q.size() != 1 || err_q[0] != ec[2] + TMO) begin
            bad++; $display("FAIL timeout_err: got %0d pulses first at %0d want 1 at %0d",
                            err_q.size(), (err_q.size() > 0) ? err_q[0] : -1, ec[2] + TMO);
        end
        total++;
        if (done_q.size() != 0 || out_q.size() != 3) begin
            bad++; $display("FAIL timeout_flags: got done=%0d out=%0d want 0 3", done_q.size(), out_q.size());
        end
        total++;
        if (u_if.in_ready_o !== 1'b1 || u_if.busy_o !== 1'b0) begin
            bad++; $display("FAIL timeout_idle: got ready=%b busy=%b want 1 0", u_if.in_ready_o, u_if.busy_o);
        end
    endtask
`endif

    initial begin
        u_if.in_valid_i          = 1'b0;
        u_if.in_data_i           = '0;
        u_if.in_last_i           = 1'b0;
        u_if.pipe_result_i       = '0;
        u_if.pipe_result_valid_i = 1'b0;
        test_reset();
        test_stream_and_results();
        test_stall();
        test_early_last();
        test_missing_last();
        test_reset_mid_stream();
        test_back_to_back();
`ifdef SOFTMAX_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation still running at %0t", $time);
        $fatal(1, "time limit");
    end

endmodule
